// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl
// -------------
// Multi-cycle control FSM for the RV32I core.
//
// The FSM runs one instruction at a time through FETCH, DECODE, EXEC, MEM and WB.
// It drives:
//   - the PC register's load and PCSrc inputs,
//   - the IR capture strobe,
//   - the register-file write enable,
//   - the instruction and data memory request handshakes.
// It also counts retired instructions. It traps into FAULT on an illegal
// opcode, an illegal branch funct3, or a memory request that is never acked.
//
// Only three things are registered: the state, the request wait counter and
// the retired counter. Every strobe is combinational from state, opcode,
// funct3 and the flag/ack inputs.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   run                       enable; low parks the core in IDLE at the next
//                             instruction boundary
//   opcode, funct3            instruction fields from the IR
//   alu_zero, alu_lt          ALU flags used for branch resolution
//   imem_req / imem_ack       instruction fetch handshake
//   dmem_req, dmem_we /
//   dmem_ack                  data memory handshake (dmem_we = store)
//   ir_load                   IR capture strobe
//   pc_load, pc_src           PC register load and source (1 = PC+Imm)
//   reg_write, wb_sel         register write enable and source
//                             (0 ALU, 1 memory, 2 PC+4)
//   alu_src_imm               ALU B operand is the immediate
//   state, halted, fault      current state, IDLE flag, FAULT flag
//   retired                   retired-instruction count (wraps)

module riscv_mc_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             alu_zero,
  input  logic             alu_lt,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_load,
  output logic             pc_load,
  output logic             pc_src,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             alu_src_imm,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // The wait counter holds (request cycle - 1).
  // It therefore reaches MEM_TIMEOUT-1 in the last cycle that may still be acked.
  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [2:0]        state_q,   state_d;
  logic [WAIT_W-1:0] wait_q,    wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic is_r, is_load, is_store, is_branch, is_jal, op_legal, uses_imm;
  logic br_legal, br_taken, retire;

  // Opcode classification
  assign is_r      = (opcode == OP_R);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign op_legal  = is_r || is_load || is_store || is_branch || is_jal ||
                     (opcode == OP_I) || (opcode == OP_LUI) ||
                     (opcode == OP_AUIPC);
  assign uses_imm  = op_legal && !is_r && !is_branch;

  // Branch condition from funct3.
  // The ALU has already applied signed/unsigned compare, so BLT and BLTU
  // share alu_lt here. funct3 010 and 011 are illegal.
  always_comb begin
    br_legal = 1'b1;
    br_taken = 1'b0;
    case (funct3)
      3'b000:         br_taken = alu_zero;
      3'b001:         br_taken = !alu_zero;
      3'b100, 3'b110: br_taken = alu_lt;
      3'b101, 3'b111: br_taken = !alu_lt;
      default:        br_legal = 1'b0;
    endcase
  end

  // Next-state and strobe logic.
  // The wait counter defaults to zero, so any entry into FETCH or MEM
  // starts a fresh timeout window. A retire overrides the next state with
  // FETCH or IDLE depending on run.
  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    retired_d   = retired_q;
    retire      = 1'b0;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = 2'd0;
    alu_src_imm = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        state_d = op_legal ? S_EXEC : S_FAULT;
      end
      S_EXEC: begin
        alu_src_imm = uses_imm;
        if (!op_legal) begin
          state_d = S_FAULT;
        end else if (is_branch) begin
          if (br_legal) begin
            pc_load = 1'b1;
            pc_src  = br_taken;
            retire  = 1'b1;
          end else begin
            state_d = S_FAULT;
          end
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req    = 1'b1;
        dmem_we     = is_store;
        alu_src_imm = uses_imm;
        if (dmem_ack) begin
          if (is_store) begin
            pc_load = 1'b1;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        // PC and register file update on the same edge.
        // The PC+4 written for JAL is therefore the pre-jump value.
        reg_write = 1'b1;
        pc_load   = 1'b1;
        pc_src    = is_jal;
        wb_sel    = is_load ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
        retire    = 1'b1;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    if (retire) begin
      retired_d = retired_q + CNT_W'(1);
      state_d   = run ? S_FETCH : S_IDLE;
    end
  end

  // State, wait counter and retired counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign halted  = (state_q == S_IDLE);
  assign fault   = (state_q == S_FAULT);
  assign retired = retired_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Testbench for riscv_mc_ctrl.
//
// The expected per-cycle outputs are built one instruction at a time.
// The builder works from the instruction's class and its handshake
// latencies. Each expected cycle goes into a queue, which is then applied
// and compared cycle by cycle.
//
// The retired counter is narrowed to 8 bits so that wrap-around can be
// reached quickly.

module tb_riscv_mc_ctrl;

  localparam int T  = 16;
  localparam int CW = 8;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic          clk, rst, run, alu_zero, alu_lt, imem_ack, dmem_ack;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          imem_req, dmem_req, dmem_we, ir_load, pc_load, pc_src;
  logic          reg_write, alu_src_imm, halted, fault;
  logic [1:0]    wb_sel;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  riscv_mc_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct3(funct3),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .imem_req(imem_req),
    .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .ir_load(ir_load), .pc_load(pc_load),
    .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel),
    .alu_src_imm(alu_src_imm), .state(state), .halted(halted),
    .fault(fault), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: the inputs applied, the expected outputs, and whether the
  // instruction retires at the end of this cycle.
  typedef struct packed {
    logic       run;
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    logic       lt;
    logic       iack;
    logic       dack;
    logic [2:0] st;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_load;
    logic       pc_load;
    logic       pc_src;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       asi;
    logic       ret;
  } vec_t;

  vec_t          q[$];
  vec_t          tbl[14];
  int            checks   = 0;
  int            failures = 0;
  logic [CW-1:0] exp_retired;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Table entry helper.
  // o = {imem_req, dmem_req, dmem_we, ir_load, pc_load, pc_src,
  //      reg_write, wb_sel[1:0], asi, ret}
  function automatic vec_t mkv(input logic [2:0] st, input logic run_v,
                               input logic [6:0] op, input logic [2:0] f3,
                               input logic z, input logic lt,
                               input logic iack, input logic dack,
                               input logic [10:0] o);
    vec_t v;
    v = '0;
    v.st = st; v.run = run_v; v.op = op; v.f3 = f3;
    v.z = z; v.lt = lt; v.iack = iack; v.dack = dack;
    {v.imem_req, v.dmem_req, v.dmem_we, v.ir_load, v.pc_load, v.pc_src,
     v.reg_write, v.wb_sel, v.asi, v.ret} = o;
    return v;
  endfunction

  // A cycle with nothing expected and random values on the irrelevant inputs
  function automatic vec_t base(input logic [2:0] st, input logic run_v,
                                input logic [6:0] op, input logic [2:0] f3);
    vec_t v;
    v = '0;
    v.st = st; v.run = run_v; v.op = op; v.f3 = f3;
    v.z    = 1'($urandom);
    v.lt   = 1'($urandom);
    v.iack = 1'($urandom);
    v.dack = 1'($urandom);
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    run = v.run; opcode = v.op; funct3 = v.f3;
    alu_zero = v.z; alu_lt = v.lt; imem_ack = v.iack; dmem_ack = v.dack;
  endtask

  task automatic checkOutput(input vec_t v);
    check1("state",       32'(state),       32'(v.st));
    check1("imem_req",    32'(imem_req),    32'(v.imem_req));
    check1("dmem_req",    32'(dmem_req),    32'(v.dmem_req));
    check1("dmem_we",     32'(dmem_we),     32'(v.dmem_we));
    check1("ir_load",     32'(ir_load),     32'(v.ir_load));
    check1("pc_load",     32'(pc_load),     32'(v.pc_load));
    check1("pc_src",      32'(pc_src),      32'(v.pc_src));
    check1("reg_write",   32'(reg_write),   32'(v.reg_write));
    check1("wb_sel",      32'(wb_sel),      32'(v.wb_sel));
    check1("alu_src_imm", 32'(alu_src_imm), 32'(v.asi));
    check1("halted",      32'(halted),      32'(v.st == 3'd0));
    check1("fault",       32'(fault),       32'(v.st == 3'd6));
    check1("retired",     32'(retired),     32'(exp_retired));
  endtask

  // Apply each queued cycle at posedge+1, check at posedge+2, then clock.
  task automatic run_queue();
    vec_t v;
    while (q.size() > 0) begin
      v = q.pop_front();
      applyStimulus(v);
      #1;
      checkOutput(v);
      @(posedge clk);
      #1;
      if (v.ret) exp_retired = exp_retired + 1'b1;
    end
  endtask

  task automatic push_fault();
    q.push_back(base(3'd6, 1'($urandom), 7'h00, 3'd0));
    q.push_back(base(3'd6, 1'($urandom), 7'h00, 3'd0));
  endtask

  // After a retire with run low, the core parks in IDLE.
  // It stays there one cycle, then restarts once run returns.
  task automatic end_instr(input logic run_v);
    if (!run_v) begin
      q.push_back(base(3'd0, 1'b0, 7'h00, 3'd0));
      q.push_back(base(3'd0, 1'b1, 7'h00, 3'd0));
    end
  endtask

  // Builds the expected cycles of one instruction, starting from FETCH.
  //   flat    fetch request cycle in which imem_ack arrives (>T = never)
  //   mlat    same for dmem_ack
  //   run_v   run level from EXEC onward
  task automatic gen_instr(input logic run_v, input int flat,
                           input logic [6:0] op, input logic [2:0] f3,
                           input int mlat, output bit faulted);
    vec_t v;
    bit   br_ok, taken;
    faulted = 1'b1;
    for (int k = 1; k <= flat && k <= T; k++) begin
      v = base(3'd1, 1'b1, op, f3);
      v.iack = (k == flat);
      v.imem_req = 1'b1;
      v.ir_load = v.iack;
      q.push_back(v);
    end
    if (flat > T) begin push_fault(); return; end
    q.push_back(base(3'd2, 1'b1, op, f3));
    if (!(op inside {OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE,
                     OP_BRANCH, OP_JAL})) begin
      push_fault();
      return;
    end
    v = base(3'd3, run_v, op, f3);
    v.asi = !(op == OP_R || op == OP_BRANCH);
    if (op == OP_BRANCH) begin
      br_ok = 1'b1;
      taken = 1'b0;
      case (f3)
        3'd0:       taken = v.z;
        3'd1:       taken = !v.z;
        3'd4, 3'd6: taken = v.lt;
        3'd5, 3'd7: taken = !v.lt;
        default:    br_ok = 1'b0;
      endcase
      if (!br_ok) begin q.push_back(v); push_fault(); return; end
      v.pc_load = 1'b1; v.pc_src = taken; v.ret = 1'b1;
      q.push_back(v);
      end_instr(run_v);
      faulted = 1'b0;
      return;
    end
    q.push_back(v);
    if (op == OP_LOAD || op == OP_STORE) begin
      for (int k = 1; k <= mlat && k <= T; k++) begin
        v = base(3'd4, run_v, op, f3);
        v.dack = (k == mlat);
        v.dmem_req = 1'b1;
        v.dmem_we = (op == OP_STORE);
        v.asi = 1'b1;
        if (op == OP_STORE && v.dack) begin
          v.pc_load = 1'b1;
          v.ret = 1'b1;
        end
        q.push_back(v);
      end
      if (mlat > T) begin push_fault(); return; end
      if (op == OP_STORE) begin
        end_instr(run_v);
        faulted = 1'b0;
        return;
      end
    end
    v = base(3'd5, run_v, op, f3);
    v.reg_write = 1'b1;
    v.pc_load = 1'b1;
    v.pc_src = (op == OP_JAL);
    v.wb_sel = (op == OP_LOAD) ? 2'd1 : ((op == OP_JAL) ? 2'd2 : 2'd0);
    v.ret = 1'b1;
    q.push_back(v);
    end_instr(run_v);
    faulted = 1'b0;
  endtask

  // Reset at posedge+1.
  // The outputs are checked one unit later, before any clock edge, to show
  // that the reset takes effect asynchronously.
  task automatic do_reset();
    rst = 1'b1;
    exp_retired = '0;
    #1;
    checkOutput(mkv(3'd0, 1'b0, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic do_instr(input logic run_v, input int flat,
                          input logic [6:0] op, input logic [2:0] f3,
                          input int mlat);
    bit f;
    gen_instr(run_v, flat, op, f3, mlat, f);
    run_queue();
    if (f) begin
      do_reset();
      q.push_back(base(3'd0, 1'b1, 7'h00, 3'd0));
      run_queue();
    end
  endtask

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return T;
    if (r == 1) return T + 1;
    return 1 + (r % 3);
  endfunction

  initial begin
    logic [6:0] ops[10];
    vec_t       v;
    int         idx;
    logic [6:0] op;

    ops = '{OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, 7'h00};

    // Basic sequences: R-type, BEQ taken, BEQ not taken, BLTU taken
    tbl = '{
      mkv(3'd0, 1'b1, OP_R,      3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b0_0_0_0_0_0_0_00_0_0),
      mkv(3'd1, 1'b1, OP_R,      3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 11'b1_0_0_1_0_0_0_00_0_0),
      mkv(3'd2, 1'b1, OP_R,      3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b0_0_0_0_0_0_0_00_0_0),
      mkv(3'd3, 1'b1, OP_R,      3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b0_0_0_0_0_0_0_00_0_0),
      mkv(3'd5, 1'b1, OP_R,      3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b0_0_0_0_1_0_1_00_0_1),
      mkv(3'd1, 1'b1, OP_BRANCH, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 11'b1_0_0_1_0_0_0_00_0_0),
      mkv(3'd2, 1'b1, OP_BRANCH, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b0_0_0_0_0_0_0_00_0_0),
      mkv(3'd3, 1'b1, OP_BRANCH, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 11'b0_0_0_0_1_1_0_00_0_1),
      mkv(3'd1, 1'b1, OP_BRANCH, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 11'b1_0_0_1_0_0_0_00_0_0),
      mkv(3'd2, 1'b1, OP_BRANCH, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b0_0_0_0_0_0_0_00_0_0),
      mkv(3'd3, 1'b1, OP_BRANCH, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 11'b0_0_0_0_1_0_0_00_0_1),
      mkv(3'd1, 1'b1, OP_BRANCH, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 11'b1_0_0_1_0_0_0_00_0_0),
      mkv(3'd2, 1'b1, OP_BRANCH, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 11'b0_0_0_0_0_0_0_00_0_0),
      mkv(3'd3, 1'b1, OP_BRANCH, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 11'b0_0_0_0_1_1_0_00_0_1)
    };

    // Reset state, checked before the first clock edge
    rst = 1'b1;
    exp_retired = '0;
    applyStimulus(mkv(3'd0, 1'b0, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0));
    #1;
    checkOutput(mkv(3'd0, 1'b0, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < 14; i++) q.push_back(tbl[i]);
    run_queue();

    $display("[TB] memory and timeout corner cases");
    do_instr(1'b1, 1, OP_LOAD, 3'd2, 3);      // dmem_ack in the 3rd MEM cycle
    do_instr(1'b1, 2, OP_STORE, 3'd2, 2);
    do_instr(1'b1, T + 1, OP_R, 3'd0, 1);     // fetch never acked -> FAULT
    do_instr(1'b1, T, OP_I, 3'd0, 1);         // ack in the last allowed cycle
    do_instr(1'b1, 1, OP_LOAD, 3'd2, T + 1);  // data access never acked
    do_instr(1'b1, 1, OP_STORE, 3'd0, T);
    do_instr(1'b1, 1, OP_JALR, 3'd0, 1);      // illegal opcode
    do_instr(1'b1, 1, OP_BRANCH, 3'd2, 1);    // illegal branch funct3
    do_instr(1'b1, 1, OP_JAL, 3'd0, 1);
    do_instr(1'b0, 1, OP_LOAD, 3'd2, 2);      // run dropped mid-instruction

    $display("[TB] async reset mid-fetch");
    do_instr(1'b1, 1, OP_LUI, 3'd0, 1);
    v = base(3'd1, 1'b1, OP_R, 3'd0);
    v.iack = 1'b0;
    v.imem_req = 1'b1;
    applyStimulus(v);
    #1;
    checkOutput(v);
    rst = 1'b1;
    #1;
    check1("rst_drops_imem_req", 32'(imem_req), 32'd0);
    check1("rst_state_idle",     32'(state),    32'd0);
    check1("rst_retired_zero",   32'(retired),  32'd0);
    exp_retired = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.push_back(base(3'd0, 1'b1, 7'h00, 3'd0));
    run_queue();

    $display("[TB] retired wrap-around");
    while (exp_retired != '1) do_instr(1'b1, 1, OP_R, 3'd0, 1);
    do_instr(1'b1, 1, OP_AUIPC, 3'd0, 1);
    check1("retired_wrap", 32'(retired), 32'd0);

    $display("[TB] randomized instructions");
    for (int n = 0; n < 300; n++) begin
      idx = $urandom_range(0, 9);
      op = (idx == 9) ? 7'($urandom) : ops[idx];
      do_instr(1'($urandom_range(0, 3) != 0), pick_lat(), op,
               3'($urandom), pick_lat());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_mc_ctrl.md
Name: riscv_mc_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences instruction fetch, decode, execute, data-memory access and writeback for one instruction at a time.
- Drives the PC register's load/PCSrc inputs, the IR load strobe, the register-file write enable and the memory request handshakes.
- Also counts retired instructions and traps on illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 16: maximum request cycles to wait for imem_ack or dmem_ack before faulting (≥2).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  enable; low halts the core at the next instruction boundary.
- opcode  in  7  instr[6:0] from IR; valid from DECODE onward.
- funct3  in  3  instr[14:12] from IR.
- alu_zero  in  1  ALU result == 0.
- alu_lt  in  1  ALU less-than (signedness chosen by the ALU from funct3).
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch data valid this cycle.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data write (store) qualifier for dmem_req.
- dmem_ack  in  1  data access complete this cycle.
- ir_load  out  1  IR capture strobe.
- pc_load  out  1  to the PC register's load input.
- pc_src  out  1  to the PC register's PCSrc input (1 = PC+Imm).
- reg_write  out  1  register-file write enable.
- wb_sel  out  2  writeback source: 0 = ALU, 1 = memory, 2 = PC+4.
- alu_src_imm  out  1  ALU B operand = immediate.
- state  out  3  current state encoding.
- halted  out  1  high in IDLE.
- fault  out  1  high in FAULT.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- States and encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, FAULT = 6; encoding 7 is illegal and goes to FAULT.
- Only the state register, wait counter and retired counter are registered. All strobes are combinational from state, opcode, funct3 and the flag/ack inputs.
- Reset (asynchronous, any time, including mid-access): state = IDLE, wait counter = 0, retired = 0. Every output is 0 except halted = 1. An outstanding request is dropped the same instant.
- IDLE: if run = 1, go to FETCH next cycle; otherwise stay.
- FETCH: hold imem_req = 1. In a cycle with imem_ack = 1, assert ir_load = 1 for that cycle and go to DECODE.
- DECODE: the opcode is classified. Legal opcodes:
  - R-type 0110011, I-ALU 0010011, LUI 0110111, AUIPC 0010111
  - LOAD 0000011, STORE 0100011
  - BRANCH 1100011, JAL 1101111
  - Anything else, including JALR 1100111, goes to FAULT. Legal opcodes go to EXEC.
- alu_src_imm = 1 in EXEC and MEM for all legal opcodes except R-type and BRANCH.
- EXEC:
  - BRANCH: taken is decided by funct3: 000 = zero, 001 = !zero, 100/110 = lt, 101/111 = !lt, 010/011 = illegal (go to FAULT, no PC update). For a legal branch, assert pc_load = 1 and pc_src = taken, then retire.
  - LOAD/STORE: go to MEM.
  - All other legal opcodes: go to WB.
- MEM: hold dmem_req = 1, with dmem_we = 1 for STORE.
  - LOAD: on dmem_ack, go to WB.
  - STORE: on dmem_ack, assert pc_load = 1, pc_src = 0, then retire.
- WB: assert reg_write = 1 and pc_load = 1.
  - wb_sel: 1 for LOAD, 2 for JAL, 0 otherwise.
  - pc_src: 1 for JAL, 0 otherwise.
  - Then retire.
  - PC updates at the same edge as the register write, so the register file captures the old PC+4.
- Retire: retired increments by 1 on the retire cycle and wraps from all-ones to 0. Next state is FETCH if run = 1, otherwise IDLE. Deasserting run mid-instruction never aborts the instruction.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each request cycle without ack.
  - Ack wins if it arrives in cycle MEM_TIMEOUT of the request.
  - No ack by the end of cycle MEM_TIMEOUT means FAULT.
- FAULT: all strobes and requests are 0 and fault = 1. The PC and retired count are frozen. The state is left only by rst.
- pc_load is never asserted outside EXEC (branch), MEM (store ack) and WB, so the PC holds during every wait state.

Test Plan:
- Reset, run = 1, 0x00000033 fetched with ack in 1st request cycle: FETCH, DECODE, EXEC, WB.
  - In WB: reg_write = 1, wb_sel = 0, pc_load = 1, pc_src = 0.
  - retired = 1 after 4 cycles.
- BEQ with alu_zero = 1: pc_load = 1, pc_src = 1 in EXEC, retired +1. Repeat with alu_zero = 0: pc_src = 0. BLTU (funct3 110) with alu_lt = 1: pc_src = 1.
- LOAD with dmem_ack delayed 3 cycles: dmem_req held 3 cycles, dmem_we = 0, then WB with wb_sel = 1. STORE: dmem_we = 1, pc_load pulses on the ack cycle, no reg_write.
- imem_ack never arrives with MEM_TIMEOUT = 16: FAULT after exactly 16 request cycles, fault = 1, imem_req = 0, PC held. Ack in cycle 16 is accepted instead.
- Opcode 1100111 (JALR) or branch funct3 010: FAULT from DECODE or EXEC respectively, no pc_load. rst = 1 then returns to IDLE with retired = 0.
- Run dropped during MEM of a load: the instruction completes, goes to IDLE with halted = 1. Also check retired wraps 0xFFFFFFFF → 0 on the next retire, and async rst mid-FETCH drops imem_req immediately.
